frame_sequencer: RTL and testbench

Front-end controller for the CNN inference core (`ram_mux` / `data_ram` / `weight_ram` / `control` chain). It accepts one byte stream over a valid/ready handshake and splits each frame into a weight-load phase and a data-load phase. It drives the core's `mode`, `ram_en` and `din` inputs, then waits for the core's `out_data_flag` results and forwards them with a timeout guard. It can skip the weight phase when weights loaded earlier are reused.

---
 rtl/frame_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sequencer.sv
// -----------------------------------------------------------------------------
// frame_sequencer
//
// Front-end controller for the CNN inference core. A single valid/ready byte
// stream is split per frame into a weight-load phase (core_mode_o=1) and a
// data-load phase (core_mode_o=0). The core's result strobe is then forwarded
// with a timeout guard. The weight phase is skipped on request when a complete
// weight set is already resident in the core.
//
// Ports:
//   clk_i, rst_n_i        clock (rising edge), async active-low reset
//   start_i, reuse_w_i    frame request pulse (IDLE only), skip-weights request
//   abort_i               synchronous return to IDLE, highest priority
//   s_vld_i, s_data_i     stream byte in
//   s_rdy_o               stream ready (state decode gated by !abort_i)
//   core_mode_o           1 = weight RAM, 0 = data RAM
//   core_ram_en_o         core RAM write strobe
//   core_din_o            core write byte
//   core_out_flag_i       core result strobe
//   core_dout_i           core result byte
//   res_vld_o, res_data_o forwarded result (one-cycle pulse)
//   busy_o                state is not IDLE
//   done_o                one-cycle frame completion pulse
//   err_timeout_o         sticky drain timeout, cleared by start_i
//   w_valid_o             complete weight set is loaded in the core
//   frame_cnt_o           completed frame count, wraps
// -----------------------------------------------------------------------------
module frame_sequencer #(
  parameter int N_WEIGHT  = 54,
  parameter int N_DATA    = 64,
  parameter int N_RES     = 1,
  parameter int DRAIN_MAX = 255
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic       reuse_w_i,
  input  logic       abort_i,
  input  logic       s_vld_i,
  input  logic [7:0] s_data_i,
  output logic       s_rdy_o,
  output logic       core_mode_o,
  output logic       core_ram_en_o,
  output logic [7:0] core_din_o,
  input  logic       core_out_flag_i,
  input  logic [7:0] core_dout_i,
  output logic       res_vld_o,
  output logic [7:0] res_data_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_timeout_o,
  output logic       w_valid_o,
  output logic [7:0] frame_cnt_o
);

  localparam int CNT_MAX = (N_WEIGHT > N_DATA) ? N_WEIGHT : N_DATA;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int TIMER_W = $clog2(DRAIN_MAX + 1);
  localparam int RES_W   = $clog2(N_RES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_LOAD_D = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   byte_cnt_q;
  logic [TIMER_W-1:0] timer_q;
  logic [RES_W-1:0]   res_cnt_q;
  logic               core_mode_q;
  logic               core_ram_en_q;
  logic [7:0]         core_din_q;
  logic               res_vld_q;
  logic [7:0]         res_data_q;
  logic               busy_q;
  logic               done_q;
  logic               err_timeout_q;
  logic               w_valid_q;
  logic [7:0]         frame_cnt_q;

  logic rdy_s;
  logic accept_s;

  // Ready depends on state and abort only, never on s_vld_i.
  assign rdy_s    = ((state_q == ST_LOAD_W) || (state_q == ST_LOAD_D)) && !abort_i;
  assign accept_s = s_vld_i && rdy_s;

  // Frame FSM with all counters and registered outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      byte_cnt_q    <= '0;
      timer_q       <= '0;
      res_cnt_q     <= '0;
      core_mode_q   <= 1'b0;
      core_ram_en_q <= 1'b0;
      core_din_q    <= 8'h00;
      res_vld_q     <= 1'b0;
      res_data_q    <= 8'h00;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_timeout_q <= 1'b0;
      w_valid_q     <= 1'b0;
      frame_cnt_q   <= 8'h00;
    end else begin
      // The write strobe trails its accepted byte by one cycle; mode and data
      // are updated together with it so they always qualify the same strobe.
      core_ram_en_q <= accept_s;
      res_vld_q     <= 1'b0;
      done_q        <= 1'b0;
      if (accept_s) begin
        core_din_q  <= s_data_i;
        core_mode_q <= (state_q == ST_LOAD_W);
      end

      if (abort_i) begin
        // w_valid_q is untouched: it was already cleared on LOAD_W entry,
        // and a completed weight set survives an abort in LOAD_D/DRAIN.
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_i) begin
              err_timeout_q <= 1'b0;
              byte_cnt_q    <= '0;
              busy_q        <= 1'b1;
              if (reuse_w_i && w_valid_q) begin
                state_q <= ST_LOAD_D;
              end else begin
                state_q   <= ST_LOAD_W;
                w_valid_q <= 1'b0;
              end
            end
          end
          ST_LOAD_W: begin
            if (accept_s) begin
              if (byte_cnt_q == CNT_W'(N_WEIGHT - 1)) begin
                byte_cnt_q <= '0;
                w_valid_q  <= 1'b1;
                state_q    <= ST_LOAD_D;
              end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end
          end
          ST_LOAD_D: begin
            // A result strobe here (including the exit cycle) is ignored.
            if (accept_s) begin
              if (byte_cnt_q == CNT_W'(N_DATA - 1)) begin
                byte_cnt_q <= '0;
                timer_q    <= '0;
                res_cnt_q  <= '0;
                state_q    <= ST_DRAIN;
              end else begin
                byte_cnt_q <= byte_cnt_q + 1'b1;
              end
            end
          end
          ST_DRAIN: begin
            if (core_out_flag_i) begin
              res_vld_q  <= 1'b1;
              res_data_q <= core_dout_i;
            end
            // Final result is checked before the timeout so a result in the
            // last allowed cycle wins.
            if (core_out_flag_i && (res_cnt_q == RES_W'(N_RES - 1))) begin
              res_cnt_q   <= res_cnt_q + 1'b1;
              done_q      <= 1'b1;
              frame_cnt_q <= frame_cnt_q + 8'd1;
              state_q     <= ST_DONE;
            end else if (timer_q == TIMER_W'(DRAIN_MAX - 1)) begin
              timer_q       <= TIMER_W'(DRAIN_MAX);
              err_timeout_q <= 1'b1;
              busy_q        <= 1'b0;
              state_q       <= ST_IDLE;
            end else begin
              timer_q <= timer_q + 1'b1;
              if (core_out_flag_i) begin
                res_cnt_q <= res_cnt_q + 1'b1;
              end
            end
          end
          ST_DONE: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign s_rdy_o       = rdy_s;
  assign core_mode_o   = core_mode_q;
  assign core_ram_en_o = core_ram_en_q;
  assign core_din_o    = core_din_q;
  assign res_vld_o     = res_vld_q;
  assign res_data_o    = res_data_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_timeout_o = err_timeout_q;
  assign w_valid_o     = w_valid_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// -----------------------------------------------------------------------------
// tb_frame_sequencer
//
// Directed sequence with randomized bytes/delays. A reference model tracks the
// weight-valid flag, frame count and the expected ordered list of core writes
// (mode, byte); a negedge monitor records what the DUT actually writes.
// -----------------------------------------------------------------------------
module tb_frame_sequencer;

  localparam int NW = 54;
  localparam int ND = 64;
  localparam int DMAX = 255;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, reuse_w, abort, s_vld;
  logic [7:0] s_data;
  logic       s_rdy, core_mode, core_ram_en;
  logic [7:0] core_din;
  logic       core_out_flag;
  logic [7:0] core_dout;
  logic       res_vld;
  logic [7:0] res_data;
  logic       busy, done, err_timeout, w_valid;
  logic [7:0] frame_cnt;

  frame_sequencer #(.N_WEIGHT(NW), .N_DATA(ND), .N_RES(1), .DRAIN_MAX(DMAX)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .reuse_w_i(reuse_w),
    .abort_i(abort), .s_vld_i(s_vld), .s_data_i(s_data), .s_rdy_o(s_rdy),
    .core_mode_o(core_mode), .core_ram_en_o(core_ram_en), .core_din_o(core_din),
    .core_out_flag_i(core_out_flag), .core_dout_i(core_dout),
    .res_vld_o(res_vld), .res_data_o(res_data), .busy_o(busy), .done_o(done),
    .err_timeout_o(err_timeout), .w_valid_o(w_valid), .frame_cnt_o(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model state
  logic       m_wvalid;
  logic [7:0] m_frames;
  int         m_exp_w;
  logic [8:0] exp_q[$];
  logic [8:0] cap_q[$];
  logic [7:0] res_q[$];

  // record every core write and every forwarded result
  always @(negedge clk) begin
    if (core_ram_en) cap_q.push_back({core_mode, core_din});
    if (res_vld) res_q.push_back(res_data);
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // start a frame and stream up to 'limit' bytes (-1 = whole frame)
  task automatic load_frame(input bit reuse, input bit gaps, input bit early, input int limit);
    bit   wphase;
    int   nb;
    int   rdy_bad;
    logic [7:0] b;
    wphase  = !(reuse && m_wvalid);
    nb      = (wphase ? NW : 0) + ND;
    if (limit >= 0) nb = limit;
    m_exp_w = wphase ? NW : 0;
    rdy_bad = 0;
    exp_q.delete(); cap_q.delete(); res_q.delete();
    start = 1'b1; reuse_w = reuse;
    step();
    start = 1'b0; reuse_w = 1'b0;
    if (wphase) m_wvalid = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("err_clr_on_start", err_timeout, 0);
    chk("w_valid_on_entry", w_valid, m_wvalid);
    for (int i = 0; i < nb; i++) begin
      if (gaps && (i % 5 == 4)) begin
        s_vld = 1'b0;
        repeat (3) step();
      end
      b = 8'($urandom);
      s_vld = 1'b1; s_data = b;
      if (early && i == nb - 1) begin
        core_out_flag = 1'b1; core_dout = 8'hEE;
      end
      #1;
      if (!s_rdy) rdy_bad++;
      exp_q.push_back({(wphase && i < NW) ? 1'b1 : 1'b0, b});
      step();
    end
    s_vld = 1'b0; core_out_flag = 1'b0;
    if (wphase && nb >= NW) m_wvalid = 1'b1;
    chk("s_rdy_miss", rdy_bad, 0);
  endtask

  task automatic check_strobes();
    int nmis;
    int n1;
    nmis = 0; n1 = 0;
    chk("strobe_cnt", cap_q.size(), exp_q.size());
    foreach (cap_q[i]) begin
      if (cap_q[i][8]) n1++;
      if (i < exp_q.size() && cap_q[i] !== exp_q[i]) nmis++;
    end
    chk("strobe_seq_mis", nmis, 0);
    chk("mode1_strobes", n1, m_exp_w);
  endtask

  // deliver the result after 'dly' DRAIN cycles and check completion
  task automatic finish_frame(input int dly, input logic [7:0] val);
    chk("w_valid_loaded", w_valid, m_wvalid);
    repeat (dly) step();
    core_out_flag = 1'b1; core_dout = val;
    step();
    core_out_flag = 1'b0;
    m_frames = m_frames + 8'd1;
    chk("res_vld", res_vld, 1);
    chk("res_data", res_data, val);
    chk("done_pulse", done, 1);
    chk("frame_cnt", frame_cnt, m_frames);
    step();
    chk("idle_after_done", {busy, done, res_vld}, 3'b000);
    check_strobes();
    chk("res_count", res_q.size(), 1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; reuse_w = 1'b0; abort = 1'b0;
    s_vld = 1'b0; s_data = 8'h00; core_out_flag = 1'b0; core_dout = 8'h00;
    m_wvalid = 1'b0; m_frames = 8'h00; m_exp_w = 0;
    step(); step();
    chk("reset_outputs", {s_rdy, core_mode, core_ram_en, core_din, res_vld, res_data,
                          busy, done, err_timeout, w_valid, frame_cnt}, 32'h0);
    rst_n = 1'b1;
    step();

    // reuse refused from reset, full frame with 0x5A result
    load_frame(1'b1, 1'b0, 1'b0, -1);
    finish_frame(3, 8'h5A);
    chk("w_valid_after_full", w_valid, 1);

    // weight reuse with gaps
    load_frame(1'b1, 1'b1, 1'b0, -1);
    finish_frame(0, 8'($urandom));

    // reload with backpressure, flag in LOAD_D exit cycle, result at last allowed cycle
    load_frame(1'b0, 1'b1, 1'b1, -1);
    finish_frame(DMAX - 1, 8'($urandom));

    // timeout
    load_frame(1'b1, 1'b0, 1'b0, -1);
    n = 0;
    while (!err_timeout && n < 400) begin step(); n++; end
    chk("timeout_cycles", n, DMAX);
    chk("timeout_idle", busy, 0);
    chk("timeout_frame_cnt", frame_cnt, m_frames);
    chk("timeout_w_valid", w_valid, 1);
    check_strobes();
    chk("timeout_no_res", res_q.size(), 0);

    // start clears err, then abort in LOAD_D with a byte offered
    load_frame(1'b1, 1'b0, 1'b0, 10);
    abort = 1'b1; s_vld = 1'b1; s_data = 8'hC3;
    #1;
    chk("abort_gates_rdy", s_rdy, 0);
    step();
    abort = 1'b0; s_vld = 1'b0;
    chk("abort_d_idle", busy, 0);
    chk("abort_d_w_valid", w_valid, 1);
    step();
    chk("abort_d_strobes", cap_q.size(), 10);

    // abort after weight byte 20
    load_frame(1'b0, 1'b0, 1'b0, 21);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_w_idle", busy, 0);
    chk("abort_w_w_valid", w_valid, 0);
    step();
    chk("abort_w_strobes", cap_q.size(), 21);
    load_frame(1'b1, 1'b0, 1'b0, -1);
    finish_frame(1, 8'($urandom));

    // asynchronous reset mid LOAD_D
    load_frame(1'b1, 1'b0, 1'b0, 10);
    s_vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {s_rdy, core_mode, core_ram_en, core_din, res_vld, res_data,
                             busy, done, err_timeout, w_valid, frame_cnt}, 32'h0);
    s_vld = 1'b0;
    step();
    rst_n = 1'b1;
    m_wvalid = 1'b0; m_frames = 8'h00;
    step();

    // 256 random frames: frame counter wraps back to zero
    for (int f = 0; f < 256; f++) begin
      load_frame(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0, -1);
      finish_frame(int'($urandom_range(0, 4)), 8'($urandom));
    end
    chk("frame_cnt_wrap", frame_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
